hazard_stall_ctrl: RTL and testbench

//  Parametrised pipeline hazard/stall controller for the 5-stage MIPS pipeline; sits beside ID
//  and drives the PC, IF/ID, ID/EX and EX/MEM write enables.

---
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : MIPS 5-stage hazard/stall controller: load-use bubbles, data-memory
//            freeze with timeout, EX redirect flush, stall-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  ex_redirect,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic                  mem_timeout_err
);

    localparam int c_lu_w  = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES + 1) : 1;
    localparam int c_tmo_w = $clog2(MEM_TIMEOUT + 1);

    localparam logic [c_lu_w-1:0]  c_lu_one   = 1;
    localparam logic [c_lu_w-1:0]  c_lu_init  = LU_BUBBLES - 1;
    localparam logic [c_tmo_w-1:0] c_tmo_one  = 1;
    localparam logic [c_tmo_w-1:0] c_tmo_max  = MEM_TIMEOUT;
    localparam logic [c_tmo_w-1:0] c_tmo_last = MEM_TIMEOUT - 1;
    localparam logic [CNT_W-1:0]   c_cnt_one  = 1;
    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_lu_w-1:0]   r_lu_cnt;
    logic [c_lu_w-1:0]   w_lu_cnt_nxt;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic                r_tmo_err;
    logic                w_hazard;
    logic                w_freeze;

    // $zero never carries a dependency; rt only matters if ID actually reads it
    assign w_hazard = id_ex_mem_rd && (id_ex_rt != '0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    assign w_freeze = dmem_req && !dmem_ready;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        w_state_nxt  = r_state;
        w_lu_cnt_nxt = r_lu_cnt;

        if (w_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (ex_redirect) begin
            // Wrong-path instruction in ID: any pending load-use stall is moot
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_state_nxt  = ST_RUN;
            w_lu_cnt_nxt = '0;
        end else if (r_state == ST_LU_STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            w_lu_cnt_nxt = r_lu_cnt - c_lu_one;
            if (r_lu_cnt == c_lu_one) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LU_BUBBLES > 1) begin
                w_state_nxt  = ST_LU_STALL;
                w_lu_cnt_nxt = c_lu_init;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_lu_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    // Timeout counter saturates at MEM_TIMEOUT; the error flag is sticky
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else if (w_freeze) begin
            if (r_tmo_cnt != c_tmo_max) begin
                r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
            end
            if (r_tmo_cnt >= c_tmo_last) begin
                r_tmo_err <= 1'b1;
            end
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!pc_write && (r_stall_cycles != c_cnt_max)) begin
            r_stall_cycles <= r_stall_cycles + c_cnt_one;
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign mem_timeout_err = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed self-checking bench for hazard_stall_ctrl (three configs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    // Enable vector order: {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush}
    localparam logic [5:0] c_run    = 6'b111100;
    localparam logic [5:0] c_stall  = 6'b001110;
    localparam logic [5:0] c_freeze = 6'b000000;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_mem_rd;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       ex_redirect;
    logic       dmem_req;
    logic       dmem_ready;

    logic [5:0]  en_a, en_b, en_c;
    logic [15:0] sc_a, sc_b;
    logic [2:0]  sc_c;
    logic        err_a, err_b, err_c;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // a: LU_BUBBLES=1; b: LU_BUBBLES=3; c: MEM_TIMEOUT=4 with a 3-bit counter
    hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(en_a[5]), .if_id_write(en_a[4]), .id_ex_write(en_a[3]),
        .ex_mem_write(en_a[2]), .id_ex_bubble(en_a[1]), .if_id_flush(en_a[0]),
        .stall_cycles(sc_a), .mem_timeout_err(err_a));

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(en_b[5]), .if_id_write(en_b[4]), .id_ex_write(en_b[3]),
        .ex_mem_write(en_b[2]), .id_ex_bubble(en_b[1]), .if_id_flush(en_b[0]),
        .stall_cycles(sc_b), .mem_timeout_err(err_b));

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(3)) u_dut_c (
        .clk(clk), .reset(reset), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(en_c[5]), .if_id_write(en_c[4]), .id_ex_write(en_c[3]),
        .ex_mem_write(en_c[2]), .id_ex_bubble(en_c[1]), .if_id_flush(en_c[0]),
        .stall_cycles(sc_c), .mem_timeout_err(err_c));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_ex_mem_rd  = 1'b0;
        id_ex_rt      = 5'd0;
        if_id_rs      = 5'd0;
        if_id_rt      = 5'd0;
        if_id_uses_rt = 1'b0;
        ex_redirect   = 1'b0;
        dmem_req      = 1'b0;
        dmem_ready    = 1'b0;
    endtask

    // Advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic load_use(input logic [4:0] rt);
        id_ex_mem_rd = 1'b1;
        id_ex_rt     = rt;
        if_id_rs     = rt;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #12;
        chk_eq("rst_en_a", en_a, c_run);
        chk_eq("rst_en_b", en_b, c_run);
        chk_eq("rst_sc_b", sc_b, 0);
        chk_eq("rst_err_c", err_c, 0);
        tick();
        reset = 1'b0;
        #1;

        // T1: single bubble
        load_use(5'd5);
        chk_eq("t1_stall", en_a, c_stall);
        tick();
        idle_inputs();
        #1;
        chk_eq("t1_run", en_a, c_run);
        chk_eq("t1_sc", sc_a, 1);

        // T2: $zero and unqualified rt never stall
        do_reset();
        id_ex_mem_rd = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; #1;
        chk_eq("t2_zero", en_a, c_run);
        id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7; if_id_uses_rt = 1'b0; #1;
        chk_eq("t2_rt_unused", en_a, c_run);
        if_id_uses_rt = 1'b1; #1;
        chk_eq("t2_rt_used", en_a, c_stall);
        id_ex_mem_rd = 1'b0; #1;
        chk_eq("t2_not_load", en_a, c_run);

        // T3: three bubbles, comparators ignored after the first
        do_reset();
        load_use(5'd9);
        chk_eq("t3_b1", en_b, c_stall);
        tick();
        idle_inputs(); #1;
        chk_eq("t3_b2", en_b, c_stall);
        tick();
        chk_eq("t3_b3", en_b, c_stall);
        tick();
        chk_eq("t3_run", en_b, c_run);
        chk_eq("t3_sc", sc_b, 3);

        // T4: freeze in the second bubble
        do_reset();
        load_use(5'd9);
        tick();
        idle_inputs();
        dmem_req = 1'b1; dmem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("t4_frz%0d", i), en_b, c_freeze);
            tick();
        end
        dmem_req = 1'b0; #1;
        chk_eq("t4_b2", en_b, c_stall);
        tick();
        chk_eq("t4_b3", en_b, c_stall);
        tick();
        chk_eq("t4_run", en_b, c_run);
        chk_eq("t4_sc", sc_b, 7);
        chk_eq("t4_err", err_b, 0);

        // T5: redirect cancels the pending stall
        do_reset();
        load_use(5'd9);
        tick();
        idle_inputs();
        ex_redirect = 1'b1; #1;
        chk_eq("t5_pc", en_b[5], 1);
        chk_eq("t5_bubble", en_b[1], 1);
        chk_eq("t5_flush", en_b[0], 1);
        tick();
        ex_redirect = 1'b0; #1;
        chk_eq("t5_run1", en_b, c_run);
        tick();
        chk_eq("t5_run2", en_b, c_run);
        chk_eq("t5_sc", sc_b, 1);

        // Timeout counter restarts after a ready cycle
        do_reset();
        dmem_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            dmem_ready = (i == 3);
            #1;
            tick();
        end
        chk_eq("tmo_clear_err", err_c, 0);
        chk_eq("tmo_clear_sc", sc_c, 6);

        // T6: timeout sets on the 4th freeze edge and sticks
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0; #1;
        for (int i = 0; i < 6; i++) begin
            chk_eq($sformatf("t6_frz%0d", i), en_c, c_freeze);
            tick();
            chk_eq($sformatf("t6_err%0d", i), err_c, (i >= 3) ? 1 : 0);
        end
        chk_eq("t6_sc", sc_c, 6);
        for (int i = 0; i < 3; i++) tick();
        chk_eq("t6_sc_sat", sc_c, 7);
        chk_eq("t6_err_hold", err_c, 1);
        reset = 1'b1; dmem_req = 1'b0; #1;
        chk_eq("t6_rst_err", err_c, 0);
        chk_eq("t6_rst_en", en_c, c_run);
        chk_eq("t6_rst_sc", sc_c, 0);
        tick();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
